// File: rtl/pipe_reg_chain.sv
// Elastic register chain: DEPTH valid/data stages with combinational back-pressure,
// bubble collapse, clock enable, synchronous clear and an occupancy count.
module pipe_reg_chain #(
    parameter int WIDTH  = 18,
    parameter int DEPTH  = 2,
    parameter bit BYPASS = 1'b0,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             sclr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    generate
        if (BYPASS) begin : g_bypass
            logic w_unused_bp;

            assign out_valid   = in_valid;
            assign in_ready    = out_ready;
            assign out_data    = in_data;
            assign count       = '0;
            assign w_unused_bp = &{1'b0, clk, rst, ce, sclr};
        end else begin : g_chain
            logic [DEPTH-1:0]            r_v;
            logic [DEPTH-1:0][WIDTH-1:0] r_d;
            logic [CW-1:0]               r_cnt;
            logic [DEPTH-1:0]            w_rdy;
            logic [DEPTH-1:0]            w_up_v;
            logic [DEPTH-1:0][WIDTH-1:0] w_up_d;
            logic                        w_act;
            logic                        w_in_xfer;
            logic                        w_out_xfer;

            // A stage is ready if it or any stage downstream of it is empty, or the
            // sink accepts; built as a running OR so no signal feeds back on itself.
            always_comb begin
                logic w_acc;
                w_rdy = '0;
                w_acc = out_ready;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    w_acc    = w_acc | !r_v[i];
                    w_rdy[i] = w_acc;
                end
            end

            always_comb begin
                w_up_v    = '0;
                w_up_d    = '0;
                w_up_v[0] = in_valid;
                w_up_d[0] = in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    w_up_v[i] = r_v[i-1];
                    w_up_d[i] = r_d[i-1];
                end
            end

            assign w_act      = ce & !sclr;
            assign in_ready   = w_rdy[0] & w_act;
            assign out_valid  = r_v[DEPTH-1] & w_act;
            assign out_data   = r_d[DEPTH-1];
            assign count      = r_cnt;
            assign w_in_xfer  = in_valid & in_ready;
            assign w_out_xfer = out_valid & out_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v   <= '0;
                    r_d   <= '0;
                    r_cnt <= '0;
                end else if (sclr) begin
                    r_v   <= '0;
                    r_d   <= '0;
                    r_cnt <= '0;
                end else if (ce) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (w_rdy[i]) begin
                            r_v[i] <= w_up_v[i];
                            if (w_up_v[i]) r_d[i] <= w_up_d[i];
                        end
                    end
                    case ({w_in_xfer, w_out_xfer})
                        2'b10:   r_cnt <= r_cnt + CW'(1);
                        2'b01:   r_cnt <= r_cnt - CW'(1);
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: DEPTH=3 chain checked against a queue-of-beats model
// every cycle, plus directed literal expectations; a BYPASS=1 instance alongside.
module tb_pipe_reg_chain;
    localparam int DEP = 3;
    localparam int W   = 18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ce = 1'b1, sclr = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    logic         bp_in_valid = 1'b0, bp_out_ready = 1'b0;
    logic [W-1:0] bp_in_data = '0;
    logic         bp_in_ready, bp_out_valid;
    logic [W-1:0] bp_out_data;
    logic [1:0]   bp_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(W), .DEPTH(DEP), .BYPASS(1'b0)) dut (
        .clk(clk), .rst(rst), .ce(ce), .sclr(sclr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    pipe_reg_chain #(.WIDTH(W), .DEPTH(DEP), .BYPASS(1'b1)) dut_bp (
        .clk(clk), .rst(rst), .ce(ce), .sclr(sclr),
        .in_valid(bp_in_valid), .in_ready(bp_in_ready), .in_data(bp_in_data),
        .out_valid(bp_out_valid), .out_ready(bp_out_ready), .out_data(bp_out_data),
        .count(bp_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: ordered list of beats in flight, each tagged with its position (0 = input end).
    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } beat_t;
    beat_t        q[$];
    logic [W-1:0] m_last = '0;
    int           m_np[16];
    bit           m_leave;
    bit           m_acc_ok;

    // Where each beat would sit after the next enabled edge, oldest beat first.
    function automatic void plan();
        int ahead;
        ahead   = DEP;
        m_leave = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            if (k == 0 && q[0].pos == DEP - 1) begin
                if (out_ready) begin
                    m_leave = 1'b1;
                    m_np[0] = DEP;
                end else begin
                    m_np[0] = DEP - 1;
                end
            end else if (q[k].pos + 1 < ahead) begin
                m_np[k] = q[k].pos + 1;
            end else begin
                m_np[k] = q[k].pos;
            end
            ahead = m_np[k];
        end
        m_acc_ok = (q.size() == 0) || (m_np[q.size()-1] > 0);
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst || sclr) begin
            q.delete();
            m_last = '0;
        end else if (ce) begin
            beat_t b;
            plan();
            for (int k = 0; k < q.size(); k++) begin
                if (m_np[k] == DEP - 1 && q[k].pos < DEP - 1) m_last = q[k].d;
                q[k].pos = m_np[k];
            end
            if (m_leave) void'(q.pop_front());
            if (in_valid && m_acc_ok) begin
                b.d   = in_data;
                b.pos = 0;
                q.push_back(b);
            end
        end
    end

    always @(negedge clk) begin
        logic act;
        act = ce & !sclr;
        plan();
        chk("m_in_ready", in_ready, act & m_acc_ok);
        chk("m_out_valid", out_valid, act & (q.size() > 0) && (q.size() > 0 ? q[0].pos == DEP - 1 : 1'b0));
        chk("m_out_data", out_data, m_last);
        chk("m_count", count, q.size());
        chk("bp_valid", bp_out_valid, bp_in_valid);
        chk("bp_ready", bp_in_ready, bp_out_ready);
        chk("bp_data", bp_out_data, bp_in_data);
        chk("bp_count", bp_count, 0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int t33_ov[8]   = '{0, 0, 0, 1, 1, 1, 1, 0};
    int t33_od[8]   = '{0, 0, 0, 1, 2, 3, 4, 4};
    int t33_cnt[8]  = '{0, 1, 2, 3, 3, 2, 1, 0};
    int t34_ir[5]   = '{1, 1, 1, 0, 0};
    int t34_cnt[5]  = '{0, 1, 2, 3, 3};
    int t35_ce[12]  = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int t35_iv[12]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int t35_dat[12] = '{21, 22, 23, 23, 23, 23, 23, 24, 0, 0, 0, 0};
    int t35_cnt[12] = '{0, 1, 2, 2, 2, 2, 2, 3, 3, 2, 1, 0};
    int t35_ov[12]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    int t35_od[12]  = '{14, 14, 14, 14, 14, 14, 14, 21, 22, 23, 24, 24};
    int t35_ir[12]  = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

    initial begin
        int nxt;
        // reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        cyc();
        cyc();
        rst = 1'b0;

        // streaming, latency 3, no gaps
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 4);
            in_data  = (c < 4) ? W'(c + 1) : '0;
            #2;
            chk("s33_out_valid", out_valid, t33_ov[c]);
            chk("s33_out_data", out_data, t33_od[c]);
            chk("s33_count", count, t33_cnt[c]);
            chk("s33_in_ready", in_ready, 1);
            cyc();
        end

        // stalled output: fill, then one simultaneous accept/emit
        out_ready = 1'b0;
        nxt = 11;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = W'(nxt);
            #2;
            chk("s34_in_ready", in_ready, t34_ir[c]);
            chk("s34_count", count, t34_cnt[c]);
            if (in_ready) nxt++;
            cyc();
        end
        out_ready = 1'b1;
        in_data   = W'(nxt);
        #2;
        chk("s34_full_ov", out_valid, 1);
        chk("s34_full_od", out_data, 11);
        chk("s34_full_ir", in_ready, 1);
        chk("s34_full_cnt", count, 3);
        cyc();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #2;
        chk("s34_after_cnt", count, 3);
        chk("s34_after_od", out_data, 12);
        chk("s34_after_ir", in_ready, 0);
        cyc();
        for (int c = 0; c < 3; c++) begin
            out_ready = 1'b1;
            #2;
            chk("s34_drain_od", out_data, 12 + c);
            chk("s34_drain_ov", out_valid, 1);
            cyc();
        end
        #2;
        chk("s34_empty_cnt", count, 0);
        cyc();

        // clock-enable freeze mid-stream
        for (int c = 0; c < 12; c++) begin
            ce       = t35_ce[c][0];
            in_valid = t35_iv[c][0];
            in_data  = W'(t35_dat[c]);
            #2;
            chk("s35_count", count, t35_cnt[c]);
            chk("s35_out_valid", out_valid, t35_ov[c]);
            chk("s35_out_data", out_data, t35_od[c]);
            chk("s35_in_ready", in_ready, t35_ir[c]);
            cyc();
        end

        // synchronous clear with ce=0 while two beats are held
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'(31); cyc();
        in_valid = 1'b0; cyc();
        in_valid = 1'b1; in_data = W'(32); cyc();
        in_valid = 1'b0; sclr = 1'b1; ce = 1'b0; out_ready = 1'b1;
        #2;
        chk("s36_sclr_cnt", count, 2);
        chk("s36_sclr_ov", out_valid, 0);
        chk("s36_sclr_od", out_data, 31);
        chk("s36_sclr_ir", in_ready, 0);
        cyc();
        sclr = 1'b0; ce = 1'b1;
        #2;
        chk("s36_post_cnt", count, 0);
        chk("s36_post_ov", out_valid, 0);
        chk("s36_post_od", out_data, 0);
        cyc();
        cyc();

        // asynchronous reset while full, then a fresh beat
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = W'(41 + c);
            cyc();
        end
        in_valid = 1'b0;
        #2;
        chk("s37_full_cnt", count, 3);
        chk("s37_full_od", out_data, 41);
        rst = 1'b1;
        #1;
        chk("s37_rst_ov", out_valid, 0);
        chk("s37_rst_cnt", count, 0);
        chk("s37_rst_od", out_data, 0);
        chk("s37_rst_ir", in_ready, 1);
        #1;
        rst = 1'b0;
        cyc();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 18'h2AAAA;
        cyc();
        in_valid = 1'b0;
        in_data  = '0;
        for (int c = 1; c < 4; c++) begin
            #2;
            chk("s37_beat_ov", out_valid, (c == 3) ? 1 : 0);
            if (c == 3) chk("s37_beat_od", out_data, 18'h2AAAA);
            cyc();
        end

        // random traffic: bypass instance compared directly, chain against the model
        for (int c = 0; c < 40; c++) begin
            bp_in_valid  = 1'($urandom_range(0, 1));
            bp_out_ready = 1'($urandom_range(0, 1));
            bp_in_data   = W'($urandom);
            in_valid     = 1'($urandom_range(0, 1));
            in_data      = W'($urandom);
            out_ready    = ($urandom_range(0, 3) != 0);
            ce           = ($urandom_range(0, 4) != 0);
            sclr         = ($urandom_range(0, 15) == 0);
            #2;
            chk("s38_bp_ov", bp_out_valid, bp_in_valid);
            chk("s38_bp_ir", bp_in_ready, bp_out_ready);
            chk("s38_bp_od", bp_out_data, bp_in_data);
            chk("s38_bp_cnt", bp_count, 0);
            cyc();
        end
        ce = 1'b1; sclr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) cyc();
        #2;
        chk("end_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
